// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs and lamp/display outputs of the intersection sequencer.
// The slave modport is the scheduler; the master modport is whatever drives the requests.
interface traffic_phase_scheduler_if;
  logic       ped_req;
  logic       left_req_a;
  logic       left_req_b;
  logic       emg_req;
  logic       emg_dir;
  logic [5:0] countdown;
  logic       AG, AY, AR, AL;
  logic       BG, BY, BR, BL;
  logic       walk;
  logic       emg_active;
  logic [3:0] phase;

  modport master (
    output ped_req, left_req_a, left_req_b, emg_req, emg_dir,
    input  countdown, AG, AY, AR, AL, BG, BY, BR, BL, walk, emg_active, phase
  );

  modport slave (
    input  ped_req, left_req_a, left_req_b, emg_req, emg_dir,
    output countdown, AG, AY, AR, AL, BG, BY, BR, BL, walk, emg_active, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer with demand-driven left arrows, latched pedestrian
// all-red walk phase and emergency preemption; lamps are a Moore decode of the state.
module traffic_phase_scheduler #(
  parameter int CLK_PER_SEC = 50,
  parameter int T_GREEN     = 30,
  parameter int T_LEFT      = 15,
  parameter int T_YELLOW    = 5,
  parameter int T_WALK      = 20
) (
  input logic                      clk,
  input logic                      reset,
  traffic_phase_scheduler_if.slave bus
);
  localparam int            PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

  typedef enum logic [3:0] {
    A_GO = 4'd0, A_Y1 = 4'd1, A_LEFT = 4'd2, A_Y2 = 4'd3,
    B_GO = 4'd4, B_Y1 = 4'd5, B_LEFT = 4'd6, B_Y2 = 4'd7,
    WALK = 4'd8, EMG_Y = 4'd9, EMG_HOLD = 4'd10
  } state_t;

  state_t        state_reg, state_next;
  logic [5:0]    count_reg, count_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          left_pend_a_reg, left_pend_a_next;
  logic          left_pend_b_reg, left_pend_b_next;
  logic          ped_pend_reg, ped_pend_next;
  logic          dir_lk_reg, dir_lk_next;
  logic          armed_reg, armed_next;     // preempt requested during a yellow
  logic          y_road_reg, y_road_next;   // road showing yellow in EMG_Y (0=A)
  logic          tick, phase_end, emg_on, start_emg;
  logic          left_a_now, left_b_now, ped_now;

  function automatic logic [5:0] phase_time(input state_t s);
    phase_time = 6'd0;
    case (s)
      A_GO, B_GO:                      phase_time = 6'(T_GREEN);
      A_LEFT, B_LEFT:                  phase_time = 6'(T_LEFT);
      A_Y1, A_Y2, B_Y1, B_Y2, EMG_Y:   phase_time = 6'(T_YELLOW);
      WALK:                            phase_time = 6'(T_WALK);
      default:                         phase_time = 6'd0;
    endcase
  endfunction

  function automatic state_t go_of(input logic d);
    return d ? B_GO : A_GO;
  endfunction

  assign tick       = (presc_reg == PRESC_MAX);
  assign phase_end  = tick && (count_reg == 6'd1);
  assign emg_on     = (state_reg == EMG_Y) || (state_reg == EMG_HOLD);
  assign start_emg  = bus.emg_req && !emg_on && !armed_reg;
  assign left_a_now = left_pend_a_reg || bus.left_req_a;
  assign left_b_now = left_pend_b_reg || bus.left_req_b;
  assign ped_now    = ped_pend_reg || bus.ped_req;

  always_comb begin
    state_next  = state_reg;
    dir_lk_next = start_emg ? bus.emg_dir : dir_lk_reg;
    armed_next  = armed_reg;
    y_road_next = y_road_reg;
    case (state_reg)
      A_GO, A_LEFT, B_GO, B_LEFT: begin
        if (start_emg) begin
          if (state_reg == go_of(bus.emg_dir)) begin
            state_next = EMG_HOLD;
          end else begin
            state_next  = EMG_Y;
            y_road_next = state_reg[2];
          end
        end else if (phase_end) begin
          // GO is followed by Y1 and LEFT by Y2: the next code up
          state_next = state_t'(state_reg + 4'd1);
        end
      end
      A_Y1, A_Y2, B_Y1, B_Y2: begin
        if (start_emg) armed_next = 1'b1;
        if (phase_end) begin
          if (armed_reg || start_emg) begin
            state_next = EMG_HOLD;
          end else begin
            case (state_reg)
              A_Y1:    state_next = left_a_now ? A_LEFT : B_GO;
              A_Y2:    state_next = B_GO;
              B_Y1:    state_next = left_b_now ? B_LEFT : (ped_now ? WALK : A_GO);
              default: state_next = ped_now ? WALK : A_GO;
            endcase
          end
        end
      end
      WALK: begin
        if (start_emg)      state_next = EMG_HOLD;
        else if (phase_end) state_next = A_GO;
      end
      EMG_Y: begin
        if (phase_end) state_next = bus.emg_req ? EMG_HOLD : go_of(dir_lk_reg);
      end
      EMG_HOLD: begin
        if (!bus.emg_req) state_next = go_of(dir_lk_reg);
      end
      default: state_next = A_GO;
    endcase
    if (state_next == EMG_HOLD) armed_next = 1'b0;
  end

  always_comb begin
    count_next = count_reg;
    presc_next = tick ? '0 : presc_reg + 1'b1;
    if (state_next != state_reg) begin
      presc_next = '0;
      count_next = phase_time(state_next);
    end else if (state_reg == EMG_HOLD) begin
      presc_next = '0;
      count_next = 6'd0;
    end else if (tick) begin
      count_next = count_reg - 6'd1;
    end
  end

  // A request arriving on the clearing edge keeps the latch set
  assign left_pend_a_next = (left_pend_a_reg && !(state_next == A_LEFT && state_reg != A_LEFT))
                            || bus.left_req_a;
  assign left_pend_b_next = (left_pend_b_reg && !(state_next == B_LEFT && state_reg != B_LEFT))
                            || bus.left_req_b;
  assign ped_pend_next    = (ped_pend_reg && !(state_next == WALK && state_reg != WALK))
                            || bus.ped_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= A_GO;
      count_reg       <= 6'(T_GREEN);
      presc_reg       <= '0;
      left_pend_a_reg <= 1'b0;
      left_pend_b_reg <= 1'b0;
      ped_pend_reg    <= 1'b0;
      dir_lk_reg      <= 1'b0;
      armed_reg       <= 1'b0;
      y_road_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      presc_reg       <= presc_next;
      left_pend_a_reg <= left_pend_a_next;
      left_pend_b_reg <= left_pend_b_next;
      ped_pend_reg    <= ped_pend_next;
      dir_lk_reg      <= dir_lk_next;
      armed_reg       <= armed_next;
      y_road_reg      <= y_road_next;
    end
  end

  logic [1:0] green, yellow, left_on, red;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_road
      localparam state_t GO_S   = state_t'(4'(4 * gi));
      localparam state_t Y1_S   = state_t'(4'(4 * gi + 1));
      localparam state_t LEFT_S = state_t'(4'(4 * gi + 2));
      localparam state_t Y2_S   = state_t'(4'(4 * gi + 3));
      assign green[gi]   = (state_reg == GO_S) ||
                           (state_reg == EMG_HOLD && dir_lk_reg == 1'(gi));
      assign yellow[gi]  = (state_reg == Y1_S) || (state_reg == Y2_S) ||
                           (state_reg == EMG_Y && y_road_reg == 1'(gi));
      assign left_on[gi] = (state_reg == LEFT_S);
      assign red[gi]     = !green[gi] && !yellow[gi];
    end
  endgenerate

  assign bus.AG         = green[0];
  assign bus.AY         = yellow[0];
  assign bus.AR         = red[0];
  assign bus.AL         = left_on[0];
  assign bus.BG         = green[1];
  assign bus.BY         = yellow[1];
  assign bus.BR         = red[1];
  assign bus.BL         = left_on[1];
  assign bus.walk       = (state_reg == WALK);
  assign bus.emg_active = emg_on;
  assign bus.phase      = state_reg;
  assign bus.countdown  = count_reg;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: a phase/remaining-clocks reference model checked
// every cycle, directed scenarios with literal expectations, then randomized requests.
`timescale 1ns/1ps
module tb_traffic_phase_scheduler;
  localparam int CPS = 4, TG = 30, TL = 15, TY = 5, TW = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler #(
    .CLK_PER_SEC(CPS), .T_GREEN(TG), .T_LEFT(TL), .T_YELLOW(TY), .T_WALK(TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: current phase code and clocks left in it
  int m_phase, m_left;
  bit m_lpa, m_lpb, m_ped, m_dir, m_armed, m_yroad;

  function automatic int phase_secs(input int p);
    case (p)
      0, 4:          return TG;
      2, 6:          return TL;
      1, 3, 5, 7, 9: return TY;
      8:             return TW;
      default:       return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = TG * CPS;
    m_lpa = 0; m_lpb = 0; m_ped = 0; m_dir = 0; m_armed = 0; m_yroad = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit start, expire;
    if (reset) begin
      model_reset();
      return;
    end
    start  = bus.emg_req && !(m_phase == 9 || m_phase == 10) && !m_armed;
    expire = (m_phase != 10) && (m_left == 1);
    nxt = m_phase;
    case (m_phase)
      0, 2, 4, 6: begin
        if (start) begin
          if (m_phase == (bus.emg_dir ? 4 : 0)) nxt = 10;
          else begin
            nxt = 9;
            m_yroad = (m_phase >= 4);
          end
        end else if (expire) begin
          nxt = m_phase + 1;
        end
      end
      1, 3, 5, 7: begin
        if (start) m_armed = 1;
        if (expire) begin
          if (m_armed)          nxt = 10;
          else if (m_phase == 1) nxt = (m_lpa || bus.left_req_a) ? 2 : 4;
          else if (m_phase == 3) nxt = 4;
          else if (m_phase == 5) nxt = (m_lpb || bus.left_req_b) ? 6 : ((m_ped || bus.ped_req) ? 8 : 0);
          else                   nxt = (m_ped || bus.ped_req) ? 8 : 0;
        end
      end
      8:  if (start) nxt = 10; else if (expire) nxt = 0;
      9:  if (expire) nxt = bus.emg_req ? 10 : (m_dir ? 4 : 0);
      10: if (!bus.emg_req) nxt = m_dir ? 4 : 0;
      default: nxt = 0;
    endcase
    if (start) m_dir = bus.emg_dir;
    m_lpa = (m_lpa && !(nxt == 2 && m_phase != 2)) || bus.left_req_a;
    m_lpb = (m_lpb && !(nxt == 6 && m_phase != 6)) || bus.left_req_b;
    m_ped = (m_ped && !(nxt == 8 && m_phase != 8)) || bus.ped_req;
    if (nxt != m_phase) begin
      m_left = phase_secs(nxt) * CPS;
      if (nxt == 10) m_armed = 0;
      m_phase = nxt;
    end else if (m_phase != 10) begin
      m_left--;
    end
  endtask

  // {phase, countdown, AG, AY, AR, AL, BG, BY, BR, BL, walk, emg_active}
  function automatic logic [19:0] exp_vec();
    bit ag, ay, al, bg, by, bl;
    int cd;
    ag = (m_phase == 0) || (m_phase == 10 && !m_dir);
    ay = (m_phase == 1) || (m_phase == 3) || (m_phase == 9 && !m_yroad);
    al = (m_phase == 2);
    bg = (m_phase == 4) || (m_phase == 10 && m_dir);
    by = (m_phase == 5) || (m_phase == 7) || (m_phase == 9 && m_yroad);
    bl = (m_phase == 6);
    cd = (m_phase == 10) ? 0 : (m_left + CPS - 1) / CPS;
    return {4'(m_phase), 6'(cd), ag, ay, !ag && !ay, al, bg, by, !bg && !by, bl,
            m_phase == 8, m_phase == 9 || m_phase == 10};
  endfunction

  function automatic logic [19:0] act_vec();
    return {bus.phase, bus.countdown, bus.AG, bus.AY, bus.AR, bus.AL,
            bus.BG, bus.BY, bus.BR, bus.BL, bus.walk, bus.emg_active};
  endfunction

  initial begin
    logic [19:0] e, a;
    forever begin
      @(negedge clk);
      e = exp_vec();
      a = act_vec();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t actual=%05h required=%05h", $time, a, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_inputs();
    bus.ped_req = 0; bus.left_req_a = 0; bus.left_req_b = 0;
    bus.emg_req = 0; bus.emg_dir = 0;
  endtask

  task automatic release_reset();
    repeat (2) step();
    #1 reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    release_reset();
  endtask

  // Asynchronous reset between edges, checked before the next clock
  task automatic reset_now(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check({tag, "_phase"}, int'(bus.phase), 0);
    check({tag, "_AG"}, int'(bus.AG), 1);
    check({tag, "_BR"}, int'(bus.BR), 1);
    check({tag, "_walk"}, int'(bus.walk), 0);
    check({tag, "_emg"}, int'(bus.emg_active), 0);
    check({tag, "_cd"}, int'(bus.countdown), 30);
    release_reset();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    do_reset();

    // Plain cycle with no requests
    check("rst_phase", int'(bus.phase), 0);
    check("rst_AG", int'(bus.AG), 1);
    check("rst_BR", int'(bus.BR), 1);
    check("rst_cd", int'(bus.countdown), 30);
    run(120);
    check("ay1_AY", int'(bus.AY), 1);
    check("ay1_cd", int'(bus.countdown), 5);
    run(20);
    check("bgo_BG", int'(bus.BG), 1);
    check("bgo_AR", int'(bus.AR), 1);
    check("bgo_cd", int'(bus.countdown), 30);

    // Left-turn demand on road A
    do_reset();
    bus.left_req_a = 1; step(); bus.left_req_a = 0;
    run(139);
    check("aleft_phase", int'(bus.phase), 2);
    check("aleft_AL", int'(bus.AL), 1);
    check("aleft_AR", int'(bus.AR), 1);
    check("aleft_cd", int'(bus.countdown), 15);
    run(60);
    check("ay2_phase", int'(bus.phase), 3);
    check("ay2_cd", int'(bus.countdown), 5);
    run(20);
    check("aleft_then_bgo", int'(bus.phase), 4);
    run(280);
    check("left_latch_cleared", int'(bus.phase), 4);

    // Pedestrian walk
    do_reset();
    bus.ped_req = 1; step(); bus.ped_req = 0;
    run(279);
    check("walk_phase", int'(bus.phase), 8);
    check("walk_lamp", int'(bus.walk), 1);
    check("walk_AR", int'(bus.AR), 1);
    check("walk_BR", int'(bus.BR), 1);
    check("walk_cd", int'(bus.countdown), 20);
    run(80);
    check("walk_then_ago", int'(bus.phase), 0);
    run(280);
    check("no_second_walk", int'(bus.phase), 0);
    check("no_second_walk_lamp", int'(bus.walk), 0);
    bus.ped_req = 1; step(); bus.ped_req = 0;
    run(279);
    check("walk2_phase", int'(bus.phase), 8);
    run(10);
    reset_now("rst_walk");

    // Preempt toward B from A_GO: yellow exit then hold
    do_reset();
    run(52);
    check("pre_cd", int'(bus.countdown), 17);
    bus.emg_req = 1; bus.emg_dir = 1; step();
    check("emgy_phase", int'(bus.phase), 9);
    check("emgy_AY", int'(bus.AY), 1);
    check("emgy_cd", int'(bus.countdown), 5);
    run(20);
    check("hold_phase", int'(bus.phase), 10);
    check("hold_BG", int'(bus.BG), 1);
    check("hold_AR", int'(bus.AR), 1);
    check("hold_cd", int'(bus.countdown), 0);
    check("hold_emg", int'(bus.emg_active), 1);
    bus.emg_req = 0; step();
    check("exit_phase", int'(bus.phase), 4);
    check("exit_cd", int'(bus.countdown), 30);

    // Preempt toward A from A_GO: straight to hold, dir changes ignored
    do_reset();
    run(10);
    bus.emg_req = 1; bus.emg_dir = 0; step();
    check("holdA_phase", int'(bus.phase), 10);
    check("holdA_AG", int'(bus.AG), 1);
    check("holdA_AY", int'(bus.AY), 0);
    bus.emg_dir = 1; run(5);
    check("holdA_dir_ign_AG", int'(bus.AG), 1);
    check("holdA_dir_ign_BG", int'(bus.BG), 0);
    clear_inputs();
    reset_now("rst_hold");

    // Randomized traffic against the model
    for (int i = 0; i < 9000; i++) begin
      bus.ped_req    = ($urandom_range(0, 299) == 0);
      bus.left_req_a = ($urandom_range(0, 199) == 0);
      bus.left_req_b = ($urandom_range(0, 199) == 0);
      bus.emg_dir    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) bus.emg_req = !bus.emg_req;
      if ($urandom_range(0, 3999) == 0) begin
        $display("random reset at cycle %0d", i);
        reset_now("rst_rand");
      end
      step();
    end
    clear_inputs();
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
